// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: load/store request, response and memory-bus signals of data_mem_ctrl
// master: requester side (drives req_*, mem_rdata, mem_ack); slave: the controller.
interface data_mem_ctrl_if #(
  parameter int XLEN       = 32,
  parameter int DATA_WIDTH = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [XLEN-1:0]       req_addr;
  logic [DATA_WIDTH-1:0] req_width;
  logic [XLEN-1:0]       req_wdata;
  logic                  rsp_valid;
  logic [XLEN-1:0]       rsp_rdata;
  logic                  rsp_err;
  logic                  mem_req;
  logic                  mem_we;
  logic [XLEN-1:0]       mem_addr;
  logic [3:0]            mem_be;
  logic [XLEN-1:0]       mem_wdata;
  logic [XLEN-1:0]       mem_rdata;
  logic                  mem_ack;
  modport master (
    output req_valid, req_we, req_addr, req_width, req_wdata, mem_rdata, mem_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_width, req_wdata, mem_rdata, mem_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: aligns byte/halfword/word loads and stores onto a word-wide bus with timeout
// Ports: clk, rst (async, active-high), bus (data_mem_ctrl_if.slave: request, response, memory bus).
module data_mem_ctrl #(
  parameter int XLEN       = 32,
  parameter int DATA_WIDTH = 3,
  parameter int TIMEOUT    = 15
) (
  input logic            clk,
  input logic            rst,
  data_mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [XLEN-1:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] width_q, width_d;
  logic                  we_q, we_d, err_q, err_d;
  logic                  bad, acc, resp;
  logic [4:0]            sh;
  logic [XLEN-1:0]       load;
  function automatic logic is_word(input logic [DATA_WIDTH-1:0] w);
    return w == DATA_WIDTH'(0);
  endfunction
  function automatic logic is_half(input logic [DATA_WIDTH-1:0] w);
    return w == DATA_WIDTH'(1) || w == DATA_WIDTH'(4);
  endfunction
  function automatic logic is_byte(input logic [DATA_WIDTH-1:0] w);
    return w == DATA_WIDTH'(2) || w == DATA_WIDTH'(3);
  endfunction
  assign acc  = state_q == ACCESS;
  assign resp = state_q == RESP;
  // Error check is done on the live request so a bad access never reaches the bus.
  assign bad  = bus.req_width > DATA_WIDTH'(4) || (is_half(bus.req_width) && bus.req_addr[0]) ||
                (is_word(bus.req_width) && bus.req_addr[1:0] != 2'b00);
  assign sh   = {addr_q[1:0], 3'b000};
  assign load = (bus.mem_rdata >> sh) &
                (is_byte(width_q) ? XLEN'(8'hFF) : is_half(width_q) ? XLEN'(16'hFFFF) : '1);
  assign bus.req_ready = state_q == IDLE;
  assign bus.mem_req   = acc;
  assign bus.mem_we    = acc & we_q;
  assign bus.mem_addr  = acc ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign bus.mem_be    = !acc ? 4'b0000 : is_word(width_q) ? 4'b1111 :
                         is_half(width_q) ? 4'b0011 << addr_q[1:0] : 4'b0001 << addr_q[1:0];
  assign bus.mem_wdata = acc ? wdata_q << sh : '0;
  assign bus.rsp_valid = resp;
  assign bus.rsp_rdata = resp ? rdata_q : '0;
  assign bus.rsp_err   = resp & err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    width_d = width_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == IDLE && bus.req_valid) begin
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      width_d = bus.req_width;
      we_d    = bus.req_we;
      cnt_d   = '0;
      rdata_d = '0;
      err_d   = bad;
      state_d = bad ? RESP : ACCESS;
    end else if (acc) begin
      // An ack arriving on the last allowed cycle still wins over the timeout.
      if (bus.mem_ack) begin
        rdata_d = we_q ? '0 : load;
        err_d   = 1'b0;
        state_d = RESP;
      end else if (cnt_q == TMO) begin
        rdata_d = '0;
        err_d   = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (resp) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and randomized load/store transactions against a byte-lane reference model
module tb_data_mem_ctrl;
  localparam int TIMEOUT = 15;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  data_mem_ctrl_if #(.XLEN(32), .DATA_WIDTH(3)) bus ();
  data_mem_ctrl #(.XLEN(32), .DATA_WIDTH(3), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_quiet(input string tag);
    chk({tag, "/req_ready"}, 32'(bus.req_ready), 1);
    chk({tag, "/mem_req"}, 32'(bus.mem_req), 0);
    chk({tag, "/mem_we"}, 32'(bus.mem_we), 0);
    chk({tag, "/mem_be"}, 32'(bus.mem_be), 0);
    chk({tag, "/mem_addr"}, bus.mem_addr, 0);
    chk({tag, "/mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "/rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "/rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "/rsp_err"}, 32'(bus.rsp_err), 0);
  endtask
  // Reference: an access covers sz bytes starting at byte offset a%4 of its word.
  function automatic void model(input logic we, input int w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, output bit bad, output logic [3:0] be,
                                output logic [31:0] ma, output logic [31:0] mwd, output logic [31:0] rdat);
    int sz, off;
    sz   = (w == 0) ? 4 : (w == 1 || w == 4) ? 2 : (w == 2 || w == 3) ? 1 : 0;
    off  = int'(a % 4);
    bad  = sz == 0 || (a % sz) != 0;
    be   = 4'(((1 << sz) - 1) << off);
    ma   = a - 32'(off);
    mwd  = 32'(64'(wd) << (8 * off));
    rdat = we ? 32'd0 : 32'((64'(rd) >> (8 * off)) % (64'd1 << (8 * sz)));
  endfunction
  task automatic txn(input string tag, input logic we, input int w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
    bit          bad, acked;
    logic [3:0]  be;
    logic [31:0] ma, mwd, rdat;
    int          n;
    model(we, w, a, wd, rd, bad, be, ma, mwd, rdat);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_width = 3'(w);
    bus.req_addr  = a;
    bus.req_wdata = wd;
    chk({tag, "/ready"}, 32'(bus.req_ready), 1);
    tick;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_width = 3'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    if (bad) begin
      chk({tag, "/err_mem_req"}, 32'(bus.mem_req), 0);
      chk({tag, "/err_rsp_valid"}, 32'(bus.rsp_valid), 1);
      chk({tag, "/err_rsp_err"}, 32'(bus.rsp_err), 1);
      chk({tag, "/err_rsp_rdata"}, bus.rsp_rdata, 0);
      chk({tag, "/err_ready"}, 32'(bus.req_ready), 0);
    end else begin
      n = 0;
      acked = 0;
      while (!acked && n <= TIMEOUT) begin
        chk({tag, "/mem_req"}, 32'(bus.mem_req), 1);
        chk({tag, "/mem_addr"}, bus.mem_addr, ma);
        chk({tag, "/mem_be"}, 32'(bus.mem_be), 32'(be));
        chk({tag, "/mem_we"}, 32'(bus.mem_we), 32'(we));
        chk({tag, "/mem_wdata"}, bus.mem_wdata, mwd);
        chk({tag, "/busy_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, "/busy_ready"}, 32'(bus.req_ready), 0);
        n++;
        if (n == ack_at) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rd;
          acked = 1;
        end else begin
          bus.mem_rdata = $urandom;
        end
        tick;
        bus.mem_ack = 1'b0;
      end
      chk({tag, "/rsp_valid"}, 32'(bus.rsp_valid), 1);
      chk({tag, "/rsp_mem_req"}, 32'(bus.mem_req), 0);
      chk({tag, "/rsp_mem_be"}, 32'(bus.mem_be), 0);
      chk({tag, "/rsp_err"}, 32'(bus.rsp_err), acked ? 0 : 1);
      chk({tag, "/rsp_rdata"}, bus.rsp_rdata, acked ? rdat : 32'd0);
    end
    tick;
    chk({tag, "/after_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "/after_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "/after_rsp_err"}, 32'(bus.rsp_err), 0);
    chk({tag, "/after_ready"}, 32'(bus.req_ready), 1);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_width = 3'd0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.mem_rdata = 32'd0;
    bus.mem_ack   = 1'b0;
    #12;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;
    tick;
    check_quiet("idle");
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    tick;
    bus.mem_ack = 1'b0;
    check_quiet("stray_ack_idle");
    txn("st_word", 1'b1, 0, 32'h100, 32'hDEADBEEF, 32'h0, 2);
    txn("ld_byte", 1'b0, 2, 32'h203, 32'h0, 32'hAB000000, 1);
    txn("st_half", 1'b1, 1, 32'h302, 32'h1234, 32'h0, 3);
    txn("ld_misalign", 1'b0, 0, 32'h101, 32'h0, 32'h0, 1);
    txn("ld_timeout", 1'b0, 0, 32'h400, 32'h0, 32'h55, 1000);
    txn("ld_hu_lastack", 1'b0, 4, 32'h402, 32'h0, 32'h8765_4321, TIMEOUT + 1);
    txn("st_bad_width", 1'b1, 6, 32'h500, 32'h1, 32'h0, 1);
    txn("ld_half_odd", 1'b0, 1, 32'h601, 32'h0, 32'h0, 1);
    txn("ld_bu", 1'b0, 3, 32'h701, 32'h0, 32'h1122_3344, 4);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_width = 3'd0;
    bus.req_addr  = 32'h800;
    tick;
    bus.req_valid = 1'b0;
    chk("rst_mid/mem_req_before", 32'(bus.mem_req), 1);
    tick;
    rst = 1'b1;
    #1;
    check_quiet("rst_mid");
    tick;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = $urandom;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_quiet("rst_stray_ack");
    end
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 60; i++) begin
      int r, ack_at;
      r = int'($urandom_range(0, 9));
      ack_at = (r == 0) ? TIMEOUT + 2 : (r == 1) ? TIMEOUT + 1 : int'($urandom_range(1, 4));
      txn("rand", 1'($urandom), int'($urandom_range(0, 7)), $urandom, $urandom, $urandom, ack_at);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- XLEN, 32, data/address width.
- DATA_WIDTH, 3, width-code width.
- TIMEOUT, 15, max wait cycles for mem_ack.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  access request from load/store stage.
- req_ready  out  1  controller can accept request.
- req_we  in  1  1=store, 0=load.
- req_addr  in  XLEN  byte address (target_addr).
- req_width  in  DATA_WIDTH  0=WORD, 1=HALFWORD, 2=BYTE, 3=BYTE_UNSIGNED, 4=HALFWORD_UNSIGNED.
- req_wdata  in  XLEN  store data, value in low bits.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  XLEN  load data, selected lane right-justified, upper bits zero.
- rsp_err  out  1  valid with rsp_valid; misaligned, illegal width, or timeout.
- mem_req  out  1  bus request, held until ack.
- mem_we  out  1  bus write enable.
- mem_addr  out  XLEN  word-aligned address (bits [1:0]=0).
- mem_be  out  4  byte enables.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_rdata  in  XLEN  bus read data, valid with mem_ack.
- mem_ack  in  1  bus completion.

Function
REQ-003 FSM states SHALL be IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-004 Request SHALL be accepted when req_valid && req_ready; req_addr, req_we, req_width and req_wdata are registered on acceptance.
REQ-005 On acceptance, misalignment (HALFWORD/HALFWORD_UNSIGNED with addr[0]=1; WORD with addr[1:0]!=0) or width code 5-7 SHALL go IDLE->RESP with rsp_err=1, no bus cycle.
REQ-006 Otherwise IDLE->ACCESS; mem_req=1 from the next cycle, held with constant mem_addr/mem_we/mem_be/mem_wdata until mem_ack.
REQ-007 mem_be SHALL be 4'b1111 for WORD, 4'b0011<<addr[1:0] for halfword codes, 4'b0001<<addr[1:0] for byte codes; mem_be=0 when mem_req=0.
REQ-008 mem_wdata SHALL be req_wdata shifted left by 8*addr[1:0] bits (byte/halfword); WORD unshifted.
REQ-009 ACCESS->RESP on mem_ack=1; load data SHALL be mem_rdata shifted right by 8*addr[1:0], masked to 8/16/32 bits per width; rsp_rdata=0 for stores.
REQ-010 Wait counter SHALL reset to 0 on entering ACCESS and increment each cycle without mem_ack; at count==TIMEOUT without ack: drop mem_req, go RESP with rsp_err=1, rsp_rdata=0.
REQ-011 mem_ack outside ACCESS SHALL be ignored.
REQ-012 RESP SHALL last exactly one cycle with rsp_valid=1, then IDLE; rsp_rdata/rsp_err SHALL be 0 when rsp_valid=0.
REQ-013 Latency: accept at cycle 0, mem_req at cycle 1; ack at cycle N gives rsp_valid at cycle N+1; error path gives rsp_valid at cycle 1.
REQ-014 Back-to-back: next request accepted no earlier than the cycle after rsp_valid.
REQ-015 Sign extension is NOT performed here; the load/store stage does it.

Reset
REQ-016 While rst=1 (asynchronous): state=IDLE, counter=0, all registered fields=0, req_ready=1, and mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_err=0.
REQ-017 rst asserted mid-ACCESS SHALL drop mem_req immediately with no response; a later mem_ack SHALL be ignored.

Verification
REQ-018 Store WORD addr=0x100, data=0xDEADBEEF, ack on 2nd cycle of mem_req -> mem_addr=0x100, mem_be=1111, mem_wdata=0xDEADBEEF, rsp_valid, rsp_err=0.
REQ-019 Load BYTE addr=0x203, mem_rdata=0xAB000000 -> mem_addr=0x200, mem_be=1000, rsp_rdata=0x000000AB.
REQ-020 Store HALFWORD addr=0x302, data=0x1234 -> mem_be=1100, mem_wdata=0x12340000.
REQ-021 Load WORD addr=0x101 -> no mem_req, rsp_valid next cycle, rsp_err=1.
REQ-022 Load with mem_ack held 0 -> mem_req for TIMEOUT+1 cycles, then rsp_err=1, mem_req=0.
REQ-023 rst pulse during ACCESS, then stray mem_ack -> all outputs 0, req_ready=1, no rsp_valid.
